fm_spy_mc: RTL

Parametrised multi-channel spy buffer for the fast-monitoring path: it generalises the fixed per-block freeze/playback control to N_CH channels of configurable width and depth. Each channel is captured into a circular buffer that shares one write pointer. Capture is armed by software, stopped by a trigger after a programmable post-trigger count or by a forced freeze, and the frozen contents can be read through a register port or replayed on a stream output. It sits between the ULT monitor taps and the FM register/mon block.

---
 rtl/fm_spy_mc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fm_spy_mc.sv
// fm_spy_mc: multi-channel spy buffer. All channels share one circular write
// pointer; capture is armed, stopped by trigger + post count or forced freeze,
// then frozen contents are read back or replayed on the pb_* stream.
// The release request port is spy_release ("release" is a reserved word).
// Optional build macro FM_SPY_TRIG_TS_EN: timestamp the accepted trigger with a
// free-running cycle counter; otherwise trig_ts is tied to 0.
module fm_spy_mc #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk_hs,
  input  logic                  rst_hs,
  input  logic [DATA_W-1:0]     ch_data [N_CH],
  input  logic                  ch_valid [N_CH],
  input  logic                  arm,
  input  logic                  trig,
  input  logic                  force_freeze,
  input  logic                  spy_release,
  input  logic [DEPTH_LOG2-1:0] post_trig,
  input  logic [1:0]            pb_mode,
  input  logic                  pb_start,
  input  logic                  pb_stop,
  input  logic [CH_W-1:0]       rd_ch,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W:0]       rd_data,
  output logic [DATA_W-1:0]     pb_data [N_CH],
  output logic                  pb_valid [N_CH],
  output logic [2:0]            state,
  output logic [DEPTH_LOG2-1:0] wr_ptr,
  output logic [DEPTH_LOG2-1:0] trig_ptr,
  output logic                  wrapped,
  output logic [31:0]           trig_ts
);
  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam int unsigned WORD_W = DATA_W + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_POST     = 3'd2,
    S_FROZEN   = 3'd3,
    S_PLAYBACK = 3'd4
  } state_t;

  state_t                state_q, state_nxt;
  logic [WORD_W-1:0]     mem [N_CH][DEPTH];
  logic [DEPTH_LOG2-1:0] post_lat, post_cnt, pb_addr, pb_cnt;
  logic                  pb_loop;
  logic                  wr_en_c, arm_acc_c, trig_acc_c, pb_go_c, pb_rd_c;

  assign state = state_q;

  // State register
  always_ff @(posedge clk_hs) begin
    if (!rst_hs) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  // Next-state and control strobes; release > force_freeze > trig > arm
  always_comb begin
    state_nxt  = state_q;
    wr_en_c    = 1'b0;
    arm_acc_c  = 1'b0;
    trig_acc_c = 1'b0;
    pb_go_c    = 1'b0;
    pb_rd_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arm) begin
          arm_acc_c = 1'b1;
          state_nxt = S_ARMED;
        end
      end
      S_ARMED: begin
        wr_en_c = 1'b1;
        if (force_freeze) begin
          state_nxt = S_FROZEN;
        end else if (trig) begin
          trig_acc_c = 1'b1;
          state_nxt  = (post_lat == '0) ? S_FROZEN : S_POST;
        end
      end
      S_POST: begin
        wr_en_c = 1'b1;
        if (force_freeze || post_cnt == DEPTH_LOG2'(1)) state_nxt = S_FROZEN;
      end
      S_FROZEN: begin
        if (spy_release) begin
          state_nxt = S_IDLE;
        end else if (pb_start && (pb_mode == 2'd1 || pb_mode == 2'd2)) begin
          pb_go_c   = 1'b1;
          state_nxt = S_PLAYBACK;
        end
      end
      S_PLAYBACK: begin
        if (spy_release) begin
          state_nxt = S_IDLE;
        end else begin
          pb_rd_c = 1'b1;
          if (pb_loop) begin
            if (pb_stop) state_nxt = S_FROZEN;
          end else if (pb_cnt == DEPTH_LOG2'(DEPTH - 1)) begin
            state_nxt = S_FROZEN;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture memory: all channels written together at the shared pointer
  always_ff @(posedge clk_hs) begin
    if (rst_hs && wr_en_c) begin
      for (int c = 0; c < int'(N_CH); c++) mem[c][wr_ptr] <= {ch_valid[c], ch_data[c]};
    end
  end

  // Pointers, post counter, readout and playback datapath
  always_ff @(posedge clk_hs) begin
    if (!rst_hs) begin
      wr_ptr   <= '0;
      trig_ptr <= '0;
      wrapped  <= 1'b0;
      post_lat <= '0;
      post_cnt <= '0;
      pb_addr  <= '0;
      pb_cnt   <= '0;
      pb_loop  <= 1'b0;
      rd_data  <= '0;
      for (int c = 0; c < int'(N_CH); c++) begin
        pb_data[c]  <= '0;
        pb_valid[c] <= 1'b0;
      end
    end else begin
      rd_data <= (32'(rd_ch) < N_CH) ? mem[rd_ch][rd_addr] : '0;
      if (arm_acc_c) begin
        wr_ptr   <= '0;
        wrapped  <= 1'b0;
        post_lat <= post_trig;
      end
      if (wr_en_c) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (wr_ptr == '1) wrapped <= 1'b1;
      end
      if (trig_acc_c) begin
        trig_ptr <= wr_ptr;
        post_cnt <= post_lat;
      end else if (state_q == S_POST) begin
        post_cnt <= post_cnt - DEPTH_LOG2'(1);
      end
      if (pb_go_c) begin
        pb_addr <= wr_ptr;
        pb_cnt  <= '0;
        pb_loop <= (pb_mode == 2'd2);
      end
      for (int c = 0; c < int'(N_CH); c++) pb_valid[c] <= 1'b0;
      if (pb_rd_c) begin
        pb_addr <= pb_addr + DEPTH_LOG2'(1);
        pb_cnt  <= pb_cnt + DEPTH_LOG2'(1);
        for (int c = 0; c < int'(N_CH); c++) begin
          pb_data[c]  <= mem[c][pb_addr][DATA_W-1:0];
          pb_valid[c] <= mem[c][pb_addr][DATA_W];
        end
      end
    end
  end

`ifdef FM_SPY_TRIG_TS_EN
  logic [31:0] cyc_cnt;

  // Free-running cycle counter sampled at an accepted trigger
  always_ff @(posedge clk_hs) begin
    if (!rst_hs) begin
      cyc_cnt <= '0;
      trig_ts <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (trig_acc_c) trig_ts <= cyc_cnt;
    end
  end
`else
  assign trig_ts = '0;
`endif

endmodule
